// File: rtl/dram_timing_tracker_if.sv
// Command-FSM <-> timing-tracker bundle: FSM state flags in, constraint qualifiers and refresh status out.
// Pure level signalling, no handshake; the master is the command FSM and the slave is the tracker.
interface dram_timing_tracker_if;
  logic       init_done;
  logic       activate_issued;
  logic       read_issued;
  logic       write_issued;
  logic       precharge_issued;
  logic       refresh_issued;
  logic       tRCD_done;
  logic       tRAS_done;
  logic       tRTP_done;
  logic       tWR_done;
  logic       tWTR_done;
  logic       tRP_done;
  logic       tRFC_done;
  logic       refresh_req;
  logic [3:0] refresh_pending;
  logic       refresh_overflow;

  modport master (
    output init_done, activate_issued, read_issued, write_issued,
           precharge_issued, refresh_issued,
    input  tRCD_done, tRAS_done, tRTP_done, tWR_done, tWTR_done, tRP_done,
           tRFC_done, refresh_req, refresh_pending, refresh_overflow
  );

  modport slave (
    input  init_done, activate_issued, read_issued, write_issued,
           precharge_issued, refresh_issued,
    output tRCD_done, tRAS_done, tRTP_done, tWR_done, tWTR_done, tRP_done,
           tRFC_done, refresh_req, refresh_pending, refresh_overflow
  );
endinterface

// File: rtl/dram_timing_tracker.sv
// JEDEC timing-constraint counters plus refresh interval timer with a bounded postponement backlog.
// Latency: tX_done drops combinationally in the start cycle and rises T cycles later; no backpressure.
module dram_timing_tracker #(
  parameter int T_RCD        = 3,
  parameter int T_RAS        = 8,
  parameter int T_RTP        = 2,
  parameter int T_WR         = 4,
  parameter int T_WTR        = 2,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 20,
  parameter int T_REFI       = 780,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dram_timing_tracker_if.slave bus
);

  localparam int              NT        = 7;
  localparam logic [15:0]     REFI_LOAD = 16'(T_REFI - 1);
  localparam logic [3:0]      PEND_MAX  = 4'(MAX_POSTPONE);

  logic act_d, rd_d, wr_d, pre_d, ref_d;
  logic act_start, rd_start, wr_start, pre_start, ref_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_d <= 1'b0;
      rd_d  <= 1'b0;
      wr_d  <= 1'b0;
      pre_d <= 1'b0;
      ref_d <= 1'b0;
    end else begin
      act_d <= bus.activate_issued;
      rd_d  <= bus.read_issued;
      wr_d  <= bus.write_issued;
      pre_d <= bus.precharge_issued;
      ref_d <= bus.refresh_issued;
    end
  end

  // Flags stay high while the FSM sits in a state; only the rising edge is a new command.
  assign act_start = bus.activate_issued  & ~act_d;
  assign rd_start  = bus.read_issued      & ~rd_d;
  assign wr_start  = bus.write_issued     & ~wr_d;
  assign pre_start = bus.precharge_issued & ~pre_d;
  assign ref_start = bus.refresh_issued   & ~ref_d;

  // Timer index: 0 RCD, 1 RAS, 2 RTP, 3 WR, 4 WTR, 5 RP, 6 RFC.
  logic [NT-1:0] tmr_start;
  logic [NT-1:0] tmr_done;

  assign tmr_start = {ref_start, pre_start, wr_start, wr_start, rd_start, act_start, act_start};

  for (genvar g = 0; g < NT; g++) begin : g_tmr
    localparam int T_SEL = (g == 0) ? T_RCD :
                           (g == 1) ? T_RAS :
                           (g == 2) ? T_RTP :
                           (g == 3) ? T_WR  :
                           (g == 4) ? T_WTR :
                           (g == 5) ? T_RP  : T_RFC;
    localparam logic [7:0] LOAD = 8'(T_SEL - 1);

    logic [7:0] cnt;

    // A start while running restarts from the full count rather than extending it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= 8'd0;
      end else if (tmr_start[g]) begin
        cnt <= LOAD;
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end

    assign tmr_done[g] = (cnt == 8'd0) & ~tmr_start[g];
  end

  assign bus.tRCD_done = tmr_done[0];
  assign bus.tRAS_done = tmr_done[1];
  assign bus.tRTP_done = tmr_done[2];
  assign bus.tWR_done  = tmr_done[3];
  assign bus.tWTR_done = tmr_done[4];
  assign bus.tRP_done  = tmr_done[5];
  assign bus.tRFC_done = tmr_done[6];

  logic [15:0] refi_cnt;
  logic [3:0]  pending;
  logic        overflow;
  logic        expiry;

  assign expiry = bus.init_done & (refi_cnt == 16'd0);

  // Interval timer free-runs once init completes, independent of when refreshes are serviced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refi_cnt <= 16'd0;
      pending  <= 4'd0;
      overflow <= 1'b0;
    end else if (!bus.init_done) begin
      refi_cnt <= REFI_LOAD;
      pending  <= 4'd0;
    end else begin
      refi_cnt <= expiry ? REFI_LOAD : refi_cnt - 16'd1;
      if (expiry && !ref_start) begin
        if (pending == PEND_MAX) begin
          overflow <= 1'b1;
        end else begin
          pending <= pending + 4'd1;
        end
      end else if (ref_start && !expiry && pending != 4'd0) begin
        pending <= pending - 4'd1;
      end
    end
  end

  assign bus.refresh_pending  = pending;
  assign bus.refresh_overflow = overflow;
  assign bus.refresh_req      = (pending != 4'd0);

endmodule

// File: tb/tb_dram_timing_tracker.sv
// Randomized bench for dram_timing_tracker against a timestamp-based reference model.
// Timers are predicted from the cycle of the last command edge; refresh expiries from the init-rise cycle modulo T_REFI.
module tb_dram_timing_tracker;
  localparam int T_RCD  = 3;
  localparam int T_RAS  = 8;
  localparam int T_RTP  = 1;
  localparam int T_WR   = 4;
  localparam int T_WTR  = 2;
  localparam int T_RP   = 3;
  localparam int T_RFC  = 20;
  localparam int T_REFI = 50;
  localparam int MAXP   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dram_timing_tracker_if bus();

  dram_timing_tracker #(
    .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RTP(T_RTP), .T_WR(T_WR), .T_WTR(T_WTR),
    .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI), .MAX_POSTPONE(MAXP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Per timer: its constraint length, and which command flag starts it (0 act,1 rd,2 wr,3 pre,4 ref).
  int    tval[7] = '{T_RCD, T_RAS, T_RTP, T_WR, T_WTR, T_RP, T_RFC};
  int    tsrc[7] = '{0, 0, 1, 2, 2, 3, 4};
  string tname[7] = '{"tRCD_done", "tRAS_done", "tRTP_done", "tWR_done", "tWTR_done", "tRP_done", "tRFC_done"};

  logic [4:0] prev_fl;
  int         last_start[7];
  logic       init_prev;
  int         init_start;
  int         exp_pend;
  bit         exp_ovf;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    prev_fl    = 5'b0;
    init_prev  = 1'b0;
    init_start = 0;
    exp_pend   = 0;
    exp_ovf    = 1'b0;
    for (int t = 0; t < 7; t++) last_start[t] = -1;
  endtask

  function automatic logic [4:0] flags();
    return {bus.refresh_issued, bus.precharge_issued, bus.write_issued,
            bus.read_issued, bus.activate_issued};
  endfunction

  // Compare the current cycle's outputs, then advance the model by one cycle.
  task automatic check_cycle();
    logic [4:0] fl;
    logic [4:0] st;
    logic [6:0] got;
    logic       ini;
    bit         expd;
    bit         exp_done;
    fl  = flags();
    st  = fl & ~prev_fl;
    got = {bus.tRFC_done, bus.tRP_done, bus.tWTR_done, bus.tWR_done,
           bus.tRTP_done, bus.tRAS_done, bus.tRCD_done};
    for (int t = 0; t < 7; t++) begin
      exp_done = !st[tsrc[t]] && (last_start[t] < 0 || (cyc - last_start[t]) >= tval[t]);
      chk(tname[t], 16'(got[t]), 16'(exp_done));
    end
    chk("refresh_req", 16'(bus.refresh_req), 16'(exp_pend != 0));
    chk("refresh_pending", 16'(bus.refresh_pending), 16'(exp_pend));
    chk("refresh_overflow", 16'(bus.refresh_overflow), 16'(exp_ovf));

    for (int t = 0; t < 7; t++) if (st[tsrc[t]]) last_start[t] = cyc;
    ini = bus.init_done;
    if (ini && !init_prev) init_start = cyc;
    expd = ini && (((cyc - init_start) % T_REFI) == T_REFI - 1);
    if (!ini) begin
      exp_pend = 0;
    end else if (expd && !st[4]) begin
      if (exp_pend == MAXP) exp_ovf = 1'b1;
      else exp_pend++;
    end else if (st[4] && !expd && exp_pend > 0) begin
      exp_pend--;
    end
    init_prev = ini;
    prev_fl   = fl;
    cyc++;
  endtask

  // Choose inputs for the cycle now starting; called just after the rising edge.
  task automatic drive(input int p_tog, input bit use_ref, input bit free_init);
    if ($urandom_range(p_tog - 1) == 0) bus.activate_issued  = ~bus.activate_issued;
    if ($urandom_range(p_tog - 1) == 0) bus.read_issued      = ~bus.read_issued;
    if ($urandom_range(p_tog - 1) == 0) bus.write_issued     = ~bus.write_issued;
    if ($urandom_range(p_tog - 1) == 0) bus.precharge_issued = ~bus.precharge_issued;
    if (!use_ref) begin
      bus.refresh_issued = 1'b0;
    end else begin
      if ($urandom_range(29) == 0) bus.refresh_issued = ~bus.refresh_issued;
      // Aim some refresh edges at an expiry cycle to hit the coincident case.
      if (init_prev && bus.init_done && !bus.refresh_issued && !prev_fl[4] &&
          (((cyc - init_start) % T_REFI) == T_REFI - 1) && $urandom_range(1) == 1)
        bus.refresh_issued = 1'b1;
    end
    if (free_init) begin
      if (bus.init_done) begin
        if ($urandom_range(399) == 0) bus.init_done = 1'b0;
      end else if ($urandom_range(19) == 0) begin
        bus.init_done = 1'b1;
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset                = 1'b1;
    bus.init_done        = 1'b0;
    bus.activate_issued  = 1'b0;
    bus.read_issued      = 1'b0;
    bus.write_issued     = 1'b0;
    bus.precharge_issued = 1'b0;
    bus.refresh_issued   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then init held high with no refresh service so the backlog saturates and overflows.
    for (int i = 0; i < 520; i++) begin
      if (i > 0) drive(4, 1'b0, 1'b0);
      bus.init_done = (i >= 2);
      next_cycle();
    end

    // Asynchronous reset between edges must clear everything at once.
    #2;
    reset                = 1'b1;
    bus.activate_issued  = 1'b0;
    bus.read_issued      = 1'b0;
    bus.write_issued     = 1'b0;
    bus.precharge_issued = 1'b0;
    bus.refresh_issued   = 1'b0;
    bus.init_done        = 1'b0;
    #1;
    chk("rst_done_all", 16'({bus.tRCD_done, bus.tRAS_done, bus.tRTP_done, bus.tWR_done,
                              bus.tWTR_done, bus.tRP_done, bus.tRFC_done}), 16'h7f);
    chk("rst_refresh_req", 16'(bus.refresh_req), 16'd0);
    chk("rst_pending", 16'(bus.refresh_pending), 16'd0);
    chk("rst_overflow", 16'(bus.refresh_overflow), 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    // A flag already high at reset release starts its timers in the first cycle.
    bus.activate_issued = 1'b1;
    bus.write_issued    = 1'b1;
    next_cycle();

    // Free-running random traffic with refresh service and occasional init_done drops.
    for (int i = 0; i < 2500; i++) begin
      drive((i < 1200) ? 4 : 8, 1'b1, 1'b1);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
